// File: rtl/sign_mult_pkg.sv
// Shared widths, state encoding and saturation limits for the signed product
// accumulator and its saturating adder.
package sign_mult_pkg;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 24;
  localparam int CNT_W  = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  function automatic logic [ACC_W-1:0] sext(input logic [PROD_W-1:0] p);
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/sat_add_signed.sv
// Combinational W-bit signed saturating adder. Overflow is detected from the
// top two bits of the (W+1)-bit sum; the clamp direction follows the true sign.
module sat_add_signed #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat_hit
);

  logic [W:0] full;

  assign full = {a[W-1], a} + {b[W-1], b};

  always_comb begin
    sat_hit = full[W] ^ full[W-1];
    sum     = full[W-1:0];
    if (sat_hit) begin
      sum = full[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/signed_prod_accum.sv
// Accumulates a stream of signed products into a saturated dot-product sum and
// holds sum, beat count and overflow on a valid/ready output until consumed.
//
//  state | meaning
//  ACCUM | accepting products, in_ready=1
//  DONE  | result held on out_*, waiting for out_ready
module signed_prod_accum #(
  parameter int PROD_W = sign_mult_pkg::PROD_W,
  parameter int ACC_W  = sign_mult_pkg::ACC_W,
  parameter int CNT_W  = sign_mult_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  import sign_mult_pkg::*;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   acc_next;
  logic               sat_hit;

  assign prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};

  sat_add_signed #(.W(ACC_W)) u_sat_add (
    .a       (acc),
    .b       (prod_ext),
    .sum     (acc_next),
    .sat_hit (sat_hit)
  );

  // Gated by rst so nothing upstream sees a ready while the stage is held in reset.
  assign in_ready  = (state == ACCUM) && !rst;
  assign out_valid = (state == DONE);
  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_ovf   = ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc <= acc_next;
            if (!(&cnt)) cnt <= cnt + 1'b1;
            ovf <= ovf | sat_hit;
            if (in_last) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_prod_accum.sv
// Scoreboard bench for signed_prod_accum: a driver computes each vector's expected
// result with plain integer arithmetic and queues it; a monitor pops on every handshake.
module tb_signed_prod_accum;

  localparam longint SMAX = 8388607;
  localparam longint SMIN = -8388608;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_prod = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  signed_prod_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] sum;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  exp_t   q[$];
  exp_t   e;
  int     checks = 0;
  int     fails  = 0;

  longint m_sum = 0;
  int     m_cnt = 0;
  bit     m_ovf = 0;

  bit     rand_ready  = 0;
  bit     fixed_ready = 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
  end

  // Monitor: pop on handshake, otherwise require held outputs to stay put.
  bit          holding = 0;
  logic [23:0] h_sum;
  logic [7:0]  h_cnt;
  logic        h_ovf;

  always @(negedge clk) begin
    if (rst) begin
      holding = 0;
    end else if (out_valid) begin
      if (holding) begin
        check("hold_sum", out_sum, h_sum);
        check("hold_count", out_count, h_cnt);
        check("hold_ovf", out_ovf, h_ovf);
      end
      if (out_ready) begin
        holding = 0;
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_sum", out_sum, e.sum);
          check("out_count", out_count, e.cnt);
          check("out_ovf", out_ovf, e.ovf);
        end
      end else begin
        holding = 1;
        h_sum = out_sum;
        h_cnt = out_count;
        h_ovf = out_ovf;
      end
    end
  end

  function automatic void model_clear();
    m_sum = 0;
    m_cnt = 0;
    m_ovf = 0;
  endfunction

  // Leaves the caller at posedge+1. After a non-last beat in_valid stays high so
  // the next call can issue a back-to-back beat.
  task automatic send(input logic [15:0] prod, input bit last, input int bubbles);
    bit acc = 0;
    int n   = 0;
    for (int i = 0; i < bubbles; i++) begin
      in_valid = 1'b0;
      in_prod  = 16'($urandom);
      in_last  = 1'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_prod  = prod;
    in_last  = last;
    while (!acc && n < 3000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) begin
      check("beat_accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    m_sum = m_sum + longint'($signed(prod));
    if (m_sum > SMAX) begin
      m_sum = SMAX; m_ovf = 1;
    end else if (m_sum < SMIN) begin
      m_sum = SMIN; m_ovf = 1;
    end
    if (m_cnt < 255) m_cnt++;
    if (last) begin
      q.push_back('{sum: m_sum[23:0], cnt: m_cnt[7:0], ovf: m_ovf});
      model_clear();
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
      check("latency_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("queue_drained", q.size(), 0);
  endtask

  initial begin
    int len;
    logic [15:0] p;

    // Reset state
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    check("rst_out_ovf", out_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", in_ready, 1);

    // 1: basic vector
    send(16'd20, 0, 0);
    send(-16'sd20, 0, 0);
    send(16'd252, 0, 0);
    send(-16'sd60, 1, 0);
    drain(20);

    // 2: single beat
    send(16'hFFE7, 1, 1);
    drain(20);

    // 3: stalled result, inputs must be ignored
    fixed_ready = 0;
    @(posedge clk); #1;
    send(16'd100, 0, 0);
    send(-16'sd7, 0, 2);
    send(16'd31, 1, 0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_prod  = 16'($urandom);
      in_last  = 1'($urandom);
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    fixed_ready = 1;
    drain(20);
    send(16'd7, 0, 0);
    send(16'd8, 1, 0);
    drain(20);

    // 4: long runs saturating positive then negative
    for (int i = 0; i < 600; i++) send(16'd16384, i == 599, 0);
    drain(20);
    for (int i = 0; i < 600; i++) send(16'hC000, i == 599, 0);
    drain(20);

    // 5: reset mid-vector discards the partial sum
    send(16'd11, 0, 0);
    send(16'd22, 0, 0);
    send(16'd33, 0, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_count", out_count, 0);
    check("midrst_out_sum", out_sum, 0);
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_valid", out_valid, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("after_rst_no_valid", out_valid, 0);
    @(posedge clk); #1;
    send(16'd5, 0, 0);
    send(-16'sd3, 1, 0);
    drain(20);

    // 6: random bubbles and output stalls
    rand_ready = 1;
    for (int v = 0; v < 1000; v++) begin
      len = (v % 250 == 125) ? 300 : $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        case ($urandom_range(0, 5))
          0: p = 16'h7FFF;
          1: p = 16'h8000;
          default: p = 16'($urandom);
        endcase
        if (len > 8) p = v[0] ? 16'h8001 : 16'h7FFF;
        send(p, b == len - 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      end
    end
    drain(400);
    rand_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
